// File: rtl/contador_param.sv
// contador_param: WIDTH-bit timeout/sequence counter placed next to the FSM blocks.
//
// Features: count enable, synchronous clear, free-run or start-triggered one-shot mode,
// wrap or saturate at the terminal value, a registered one-cycle terminal pulse and a
// registered count >= max flag.
//
// Optional down counting is compiled in with the macro CONTADOR_DOWN_EN. This adds the
// i_up_down input. Without the macro the counter counts up only.
//
// Parameters
//   WIDTH     width of the counter, of i_max_number and of o_count (>= 1)
//   SATURATE  0: wrap at the terminal value; 1: hold at the terminal value (free-run only)
//
// Ports
//   i_clock            rising-edge clock
//   i_reset            asynchronous reset, active low
//   i_enable           a count step is allowed this cycle
//   i_up_down          1: count up, 0: count down (only with CONTADOR_DOWN_EN)
//   i_clear            synchronous clear, active high
//   i_one_shot         0: free-run; 1: one-shot, triggered by i_start
//   i_start            one-shot trigger, sampled only in IDLE or DONE
//   i_max_number       terminal value, registered every cycle
//   o_count            current count (registered)
//   o_bigger_than_max  o_count >= registered max (registered, aligned with o_count)
//   o_terminal         one-cycle pulse when the count reaches its terminal value
//   o_busy             1 while the one-shot FSM is in RUN
module contador_param #(
  parameter int unsigned WIDTH    = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
`ifdef CONTADOR_DOWN_EN
  input  logic             i_up_down,
`endif
  input  logic             i_clear,
  input  logic             i_one_shot,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_max_number,
  output logic [WIDTH-1:0] o_count,
  output logic             o_bigger_than_max,
  output logic             o_terminal,
  output logic             o_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_count, w_count_d;
  logic [WIDTH-1:0]   r_max_q;
  logic               r_terminal, w_terminal_d;
  logic               r_bigger, w_bigger_d;
  // Set while a saturating free-run counter sits at its terminal value after the pulse.
  logic               r_sat, w_sat_d;

  logic               w_up;
  logic               w_max_chg;
  logic [WIDTH-1:0]   w_term_val;
  logic [WIDTH-1:0]   w_wrap_val;
  logic [WIDTH-1:0]   w_start_val;
  logic [WIDTH-1:0]   w_step_val;
  logic               w_at_term;

`ifdef CONTADOR_DOWN_EN
  assign w_up = i_up_down;
`else
  assign w_up = 1'b1;
`endif

  assign w_max_chg = (i_max_number != r_max_q);

  // Up: run 0 -> max and stop or wrap at max. Down: run max -> 0 and stop or wrap at 0.
  always_comb begin
    w_term_val  = r_max_q;
    w_wrap_val  = '0;
    w_start_val = '0;
    w_step_val  = r_count + WIDTH'(1);
    if (!w_up) begin
      w_term_val  = '0;
      w_wrap_val  = r_max_q;
      w_start_val = r_max_q;
      w_step_val  = r_count - WIDTH'(1);
    end
  end

  assign w_at_term = (r_count == w_term_val);

  // Priority: clear > max change > start > enable step.
  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_terminal_d = 1'b0;
    w_sat_d      = 1'b0;
    if (i_clear) begin
      w_count_d = '0;
      w_state_d = StIdle;
    end else if (w_max_chg) begin
      // Restart: an up counter starts again from 0, a down counter from the new max.
      w_count_d = w_up ? '0 : i_max_number;
      w_state_d = StIdle;
    end else if (!i_one_shot) begin
      w_state_d = StIdle;
      if (i_enable) begin
        if (w_at_term) begin
          if (SATURATE) begin
            // Pulse once on the first enabled cycle at the terminal value, then hold quietly.
            w_count_d    = r_count;
            w_terminal_d = ~r_sat;
            w_sat_d      = 1'b1;
          end else begin
            w_count_d    = w_wrap_val;
            w_terminal_d = 1'b1;
          end
        end else begin
          w_count_d = w_step_val;
        end
      end else begin
        w_sat_d = r_sat;
      end
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_count_d = w_start_val;
            // A start value that is already terminal (max = 0) finishes at once.
            if (w_start_val == w_term_val) begin
              w_state_d    = StDone;
              w_terminal_d = 1'b1;
            end else begin
              w_state_d = StRun;
            end
          end
        end
        StRun: begin
          if (i_enable) begin
            w_count_d = w_step_val;
            if (w_step_val == w_term_val) begin
              w_state_d    = StDone;
              w_terminal_d = 1'b1;
            end
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // Compare against the max value that is registered on the same edge as the new count.
  assign w_bigger_d = (w_count_d >= i_max_number);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_max_q    <= '0;
      r_terminal <= 1'b0;
      r_bigger   <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_max_q    <= i_max_number;
      r_terminal <= w_terminal_d;
      r_bigger   <= w_bigger_d;
      r_sat      <= w_sat_d;
    end
  end

  assign o_count           = r_count;
  assign o_bigger_than_max = r_bigger;
  assign o_terminal        = r_terminal;
  assign o_busy            = (r_state == StRun);

endmodule

// File: tb/tb_contador_param.sv
// Testbench for contador_param. Two instances share all inputs: u_wrap with SATURATE=0
// and u_sat with SATURATE=1. Every expected value is pushed into a queue when its
// stimulus is issued. A monitor pops the queue and compares the entry with the outputs
// of the selected instance.
module tb_contador_param;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       one_shot;
  logic       start;
  logic [2:0] max_number;

  logic [2:0] w_cnt, s_cnt;
  logic       w_btm, s_btm, w_term, s_term, w_busy, s_busy;

  typedef struct {
    logic       sel;
    logic [2:0] cnt;
    logic       btm;
    logic       term;
    logic       busy;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  contador_param #(.WIDTH(3), .SATURATE(1'b0)) u_wrap (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_enable          (enable),
`ifdef CONTADOR_DOWN_EN
    .i_up_down         (up_down),
`endif
    .i_clear           (clear),
    .i_one_shot        (one_shot),
    .i_start           (start),
    .i_max_number      (max_number),
    .o_count           (w_cnt),
    .o_bigger_than_max (w_btm),
    .o_terminal        (w_term),
    .o_busy            (w_busy)
  );

  contador_param #(.WIDTH(3), .SATURATE(1'b1)) u_sat (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_enable          (enable),
`ifdef CONTADOR_DOWN_EN
    .i_up_down         (up_down),
`endif
    .i_clear           (clear),
    .i_one_shot        (one_shot),
    .i_start           (start),
    .i_max_number      (max_number),
    .o_count           (s_cnt),
    .o_bigger_than_max (s_btm),
    .o_terminal        (s_term),
    .o_busy            (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic sel, input logic [2:0] ec, input logic eb, input logic et,
                      input logic ebz, input string nm);
    exp_t e;
    e.sel  = sel;
    e.cnt  = ec;
    e.btm  = eb;
    e.term = et;
    e.busy = ebz;
    e.name = nm;
    q.push_back(e);
  endtask

  // Drive the inputs, wait for the next rising edge and queue the outputs expected after
  // that edge. Returns 1 time unit after the edge.
  task automatic apply(input logic en, input logic clr, input logic os, input logic st,
                       input logic ud, input logic [2:0] mx, input logic sel,
                       input logic [2:0] ec, input logic eb, input logic et, input logic ebz,
                       input string nm);
    enable     = en;
    clear      = clr;
    one_shot   = os;
    start      = st;
    up_down    = ud;
    max_number = mx;
    @(posedge clk);
    push(sel, ec, eb, et, ebz, nm);
    #1;
  endtask

  // Monitor: on each falling edge, or on demand between edges, compare one queued entry.
  initial begin
    exp_t       e;
    logic [5:0] got, want;
    forever begin
      @(negedge clk or chk_ev);
      if (q.size() > 0) begin
        e    = q.pop_front();
        got  = e.sel ? {s_cnt, s_btm, s_term, s_busy} : {w_cnt, w_btm, w_term, w_busy};
        want = {e.cnt, e.btm, e.term, e.busy};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got cnt=%0d btm=%b term=%b busy=%b, expected cnt=%0d btm=%b term=%b busy=%b",
                   e.name, got[5:3], got[2], got[1], got[0], e.cnt, e.btm, e.term, e.busy);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    up_down    = 1'b1;
    clear      = 1'b0;
    one_shot   = 1'b0;
    start      = 1'b0;
    max_number = 3'd5;

    // Reset state, checked between edges.
    #12;
    push(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "reset_wrap");
    -> chk_ev;
    #1;
    push(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, "reset_sat");
    -> chk_ev;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: free-run wrap, max=5.
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd0, 0, 0, 0, "t1_maxload");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd1, 0, 0, 0, "t1_c1");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd2, 0, 0, 0, "t1_c2");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd3, 0, 0, 0, "t1_c3");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd4, 0, 0, 0, "t1_c4");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd5, 1, 0, 0, "t1_c5");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd0, 0, 1, 0, "t1_wrap");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd1, 0, 0, 0, "t1_c1b");
    apply(0, 0, 0, 0, 1, 3'd5, 0, 3'd1, 0, 0, 0, "t1_hold");

    // Test 2: saturating instance, max=3.
    apply(1, 0, 0, 0, 1, 3'd3, 1, 3'd0, 0, 0, 0, "t2_maxload");
    apply(1, 0, 0, 0, 1, 3'd3, 1, 3'd1, 0, 0, 0, "t2_c1");
    apply(1, 0, 0, 0, 1, 3'd3, 1, 3'd2, 0, 0, 0, "t2_c2");
    apply(1, 0, 0, 0, 1, 3'd3, 1, 3'd3, 1, 0, 0, "t2_c3");
    apply(1, 0, 0, 0, 1, 3'd3, 1, 3'd3, 1, 1, 0, "t2_sat_pulse");
    apply(1, 0, 0, 0, 1, 3'd3, 1, 3'd3, 1, 0, 0, "t2_sat_hold");
    apply(1, 0, 0, 0, 1, 3'd3, 1, 3'd3, 1, 0, 0, "t2_sat_hold2");

    // Test 3: one-shot, max=4, enable toggled.
    apply(0, 0, 1, 0, 1, 3'd4, 0, 3'd0, 0, 0, 0, "t3_maxload");
    apply(0, 0, 1, 1, 1, 3'd4, 0, 3'd0, 0, 0, 1, "t3_start");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd1, 0, 0, 1, "t3_r1");
    apply(0, 0, 1, 0, 1, 3'd4, 0, 3'd1, 0, 0, 1, "t3_r1_hold");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd2, 0, 0, 1, "t3_r2");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd3, 0, 0, 1, "t3_r3");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd4, 1, 1, 0, "t3_done");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd4, 1, 0, 0, "t3_done_hold");
    apply(0, 0, 1, 1, 1, 3'd4, 0, 3'd0, 0, 0, 1, "t3_restart");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd1, 0, 0, 1, "t3_rr1");

    // Test 4: max change mid-count, then clear together with start.
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd0, 0, 0, 0, "t4_maxload");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd1, 0, 0, 0, "t4_c1");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd2, 0, 0, 0, "t4_c2");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd3, 0, 0, 0, "t4_c3");
    apply(1, 0, 0, 0, 1, 3'd5, 0, 3'd4, 0, 0, 0, "t4_c4");
    apply(1, 0, 0, 0, 1, 3'd2, 0, 3'd0, 0, 0, 0, "t4_maxchg");
    apply(1, 0, 0, 0, 1, 3'd2, 0, 3'd1, 0, 0, 0, "t4_after_chg");
    apply(1, 1, 1, 1, 1, 3'd2, 0, 3'd0, 0, 0, 0, "t4_clr_start");
    apply(1, 0, 1, 0, 1, 3'd2, 0, 3'd0, 0, 0, 0, "t4_idle");

    // max = 0 boundary: free-run pulses every enabled cycle, one-shot finishes at once.
    apply(1, 0, 0, 0, 1, 3'd0, 0, 3'd0, 1, 0, 0, "m0_load");
    apply(1, 0, 0, 0, 1, 3'd0, 0, 3'd0, 1, 1, 0, "m0_term");
    apply(1, 0, 0, 0, 1, 3'd0, 0, 3'd0, 1, 1, 0, "m0_term2");
    apply(0, 0, 1, 1, 1, 3'd0, 0, 3'd0, 1, 1, 0, "m0_os_start");
    apply(0, 0, 1, 0, 1, 3'd0, 0, 3'd0, 1, 0, 0, "m0_os_done");

    // Test 5: asynchronous reset in the middle of RUN.
    apply(0, 0, 1, 0, 1, 3'd4, 0, 3'd0, 0, 0, 0, "t5_maxload");
    apply(0, 0, 1, 1, 1, 3'd4, 0, 3'd0, 0, 0, 1, "t5_start");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd1, 0, 0, 1, "t5_r1");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd2, 0, 0, 1, "t5_r2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push(0, 3'd0, 0, 0, 0, "t5_rst_async");
    -> chk_ev;
    @(posedge clk);
    push(0, 3'd0, 0, 0, 0, "t5_rst_edge");
    #1;
    rst_n = 1'b1;
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd0, 0, 0, 0, "t5_rel_maxload");
    apply(1, 0, 1, 0, 1, 3'd4, 0, 3'd0, 0, 0, 0, "t5_rel_idle");

    // one_shot dropped mid-RUN: back to IDLE and free-run counting.
    apply(0, 0, 1, 1, 1, 3'd4, 0, 3'd0, 0, 0, 1, "os_off_start");
    apply(1, 0, 0, 0, 1, 3'd4, 0, 3'd1, 0, 0, 0, "os_off_free");

`ifdef CONTADOR_DOWN_EN
    // Test 6: down counting, one-shot, max=3.
    apply(0, 0, 1, 0, 0, 3'd3, 0, 3'd3, 1, 0, 0, "t6_maxload");
    apply(0, 0, 1, 1, 0, 3'd3, 0, 3'd3, 1, 0, 1, "t6_start");
    apply(1, 0, 1, 0, 0, 3'd3, 0, 3'd2, 0, 0, 1, "t6_c2");
    apply(1, 0, 1, 0, 0, 3'd3, 0, 3'd1, 0, 0, 1, "t6_c1");
    apply(1, 0, 1, 0, 0, 3'd3, 0, 3'd0, 0, 1, 0, "t6_done");
    apply(1, 0, 1, 0, 0, 3'd3, 0, 3'd0, 0, 0, 0, "t6_hold");
    apply(1, 0, 0, 0, 0, 3'd3, 0, 3'd3, 1, 1, 0, "t6_free_wrap");
    apply(1, 0, 0, 0, 0, 3'd3, 0, 3'd2, 0, 0, 0, "t6_free_c2");
`endif

    // Drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left in the queue, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
